pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Multi-cycle program-counter and fetch sequencer for the miniRISC core. It holds the PC and fetches one instruction from instruction memory over a req/ack handshake. It presents the instruction to the datapath, then commits the next PC when the datapath signals completion. Its registered `pc_sel` output directly drives the downstream 1-bit 2:1 PC-source mux select: 0 selects PC+4, 1 selects the branch target.

Parameters:
- ADDR_W, 32, PC / instruction-address width
- INSTR_W, 32, instruction word width
- RESET_PC, 0, PC value loaded on reset (low 2 bits must be 0)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request, held until ack
- imem_addr  output  ADDR_W  fetch address (= pc)
- imem_ack  input  1  memory returns imem_data this cycle
- imem_data  input  INSTR_W  fetched instruction
- instr  output  INSTR_W  latched current instruction
- instr_valid  output  1  instr valid, datapath may execute
- exec_done  input  1  datapath finished current instruction (1-cycle pulse)
- branch_taken  input  1  sampled with exec_done
- branch_target  input  ADDR_W  sampled with exec_done
- halt  input  1  sampled with exec_done, halt instruction executed
- pc  output  ADDR_W  current PC
- pc_plus4  output  ADDR_W  pc+4 (return address for call)
- pc_sel  output  1  registered select for the PC-source mux
- halted  output  1  core halted

Behaviour:
- Clock is `clk`. Reset is `rst_n`, asynchronous and active-low.
- Reset values:
  - state = BOOT
  - pc = RESET_PC
  - instr = 0
  - imem_req = 0, instr_valid = 0, pc_sel = 0, halted = 0
- States: BOOT, FETCH, EXEC, HALTED. State is registered; all outputs except pc_plus4 and imem_addr are registered.
- BOOT: one cycle after reset deassertion, then FETCH.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - On imem_ack: instr <= imem_data, instr_valid <= 1, go to EXEC, imem_req <= 0.
  - Minimum fetch latency is 1 cycle (ack may arrive in the first FETCH cycle).
- EXEC:
  - instr_valid holds 1.
  - On exec_done with halt = 1: go to HALTED, halted <= 1, instr_valid <= 0, pc unchanged, pc_sel unchanged.
  - On exec_done with halt = 0:
    - pc <= branch_taken ? {branch_target[ADDR_W-1:2], 2'b00} : pc+4
    - pc_sel <= branch_taken
    - instr_valid <= 0
    - go to FETCH
- HALTED: terminal; only rst_n exits. All inputs are ignored.
- Arithmetic: pc+4 is modulo 2^ADDR_W. 0xFFFFFFFC+4 = 0x00000000, no flag.
- Boundary cases:
  - imem_ack outside FETCH: ignored.
  - exec_done outside EXEC: ignored.
  - halt and branch_taken together: halt wins.
  - Misaligned branch_target: low bits forced to 0.
  - Reset mid-fetch or mid-exec: all outputs go to reset values immediately (asynchronously). A pending ack is discarded.
- Latency: exec_done to the next imem_req = 1 cycle.

Optional Feature:
- Macro: PC_RETIRE_COUNT_EN.
- Defined: adds output `retired_count` [31:0]. It resets to 0, increments on each accepted exec_done in EXEC (including halt), and saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package `minirisc_pkg`:
  - state enum (BOOT, FETCH, EXEC, HALTED)
  - ADDR_W / INSTR_W defaults
  - PC_STEP = 4 constant
- Sub-module `pc_next_logic`: combinational; computes pc_plus4, the aligned target and the next-pc mux. It is instantiated once.

Test Plan:
- Reset release with RESET_PC=0x100, ack after 2 cycles with data 0xDEADBEEF -> imem_addr=0x100, imem_req high 2 cycles, instr=0xDEADBEEF, instr_valid=1.
- Sequential: exec_done with branch_taken=0 at pc=0x100 -> pc=0x104, pc_sel=0, imem_req next cycle.
- Branch: exec_done, branch_taken=1, target=0x203 -> pc=0x200, pc_sel=1.
- Halt+branch same cycle -> halted=1, pc unchanged, no further imem_req; stray imem_ack/exec_done ignored.
- Wrap: pc=0xFFFFFFFC, sequential exec_done -> pc=0x0.
- Assert rst_n low mid-FETCH -> imem_req=0 immediately (asynchronously), pc=RESET_PC. With PC_RETIRE_COUNT_EN defined, retired_count=0 after reset and increments by 1 per exec_done.

Source files
------------

// File: rtl/minirisc_pkg.sv
// Shared types and constants for the miniRISC fetch/PC sequencer.
// Optional feature macro used by pc_sequencer: PC_RETIRE_COUNT_EN.
package minirisc_pkg;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_INSTR_W = 32;
   localparam int PC_STEP     = 4;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALTED = 2'd3
   } seq_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential increment or word-aligned branch target.
module pc_next_logic
   import minirisc_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [ADDR_W-1:0] target_aligned,
   output logic [ADDR_W-1:0] pc_next
);

   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   // Increment wraps naturally modulo 2^ADDR_W.
   assign pc_plus4       = pc + STEP;
   assign target_aligned = branch_target & ALIGN_MASK;
   assign pc_next        = branch_taken ? target_aligned : pc_plus4;

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC and fetch sequencer for the miniRISC core.
// Define PC_RETIRE_COUNT_EN to add the saturating retired_count output.
module pc_sequencer
   import minirisc_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                INSTR_W  = DEF_INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               exec_done,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               halt,
   output logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W-1:0]  pc_plus4,
   output logic               pc_sel,
`ifdef PC_RETIRE_COUNT_EN
   output logic [31:0]        retired_count,
`endif
   output logic               halted
);

   seq_state_e         state_q;
   logic [ADDR_W-1:0]  pc_q;
   logic [INSTR_W-1:0] instr_q;
   logic               imem_req_q;
   logic               instr_valid_q;
   logic               pc_sel_q;
   logic               halted_q;

   logic [ADDR_W-1:0]  pc_plus4_d;
   logic [ADDR_W-1:0]  target_aligned_d;
   logic [ADDR_W-1:0]  pc_d;

   pc_next_logic #(
      .ADDR_W (ADDR_W)
   ) u_pc_next (
      .pc             (pc_q),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .pc_plus4       (pc_plus4_d),
      .target_aligned (target_aligned_d),
      .pc_next        (pc_d)
   );

   logic accept_done;
   assign accept_done = (state_q == ST_EXEC) && exec_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         pc_sel_q      <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_BOOT: begin
               state_q    <= ST_FETCH;
               imem_req_q <= 1'b1;
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  instr_q       <= imem_data;
                  instr_valid_q <= 1'b1;
                  imem_req_q    <= 1'b0;
                  state_q       <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (exec_done) begin
                  instr_valid_q <= 1'b0;
                  // Halt has priority over a simultaneous branch; PC and select are frozen.
                  if (halt) begin
                     halted_q <= 1'b1;
                     state_q  <= ST_HALTED;
                  end else begin
                     pc_q       <= pc_d;
                     pc_sel_q   <= branch_taken;
                     imem_req_q <= 1'b1;
                     state_q    <= ST_FETCH;
                  end
               end
            end
            ST_HALTED: begin
               state_q <= ST_HALTED;
            end
            default: begin
               state_q <= ST_BOOT;
            end
         endcase
      end
   end

`ifdef PC_RETIRE_COUNT_EN
   logic [31:0] retired_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= '0;
      end else if (accept_done && (retired_q != 32'hFFFF_FFFF)) begin
         retired_q <= retired_q + 32'd1;
      end
   end

   assign retired_count = retired_q;
`else
   logic unused_accept;
   assign unused_accept = accept_done;
`endif

   assign imem_req    = imem_req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc_plus4_d;
   assign pc_sel      = pc_sel_q;
   assign halted      = halted_q;

   logic [ADDR_W-1:0] unused_target;
   assign unused_target = target_aligned_d;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_data = '0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        exec_done = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        halt = 1'b0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        pc_sel;
   logic        halted;
`ifdef PC_RETIRE_COUNT_EN
   logic [31:0] retired_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int req_cycles;

   always #5 clk = ~clk;

   pc_sequencer #(
      .ADDR_W   (32),
      .INSTR_W  (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_data     (imem_data),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .exec_done     (exec_done),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halt          (halt),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .pc_sel        (pc_sel),
`ifdef PC_RETIRE_COUNT_EN
      .retired_count (retired_count),
`endif
      .halted        (halted)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%08h", tag, got);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_with(input logic [31:0] data);
      imem_ack  = 1'b1;
      imem_data = data;
      step();
      imem_ack  = 1'b0;
   endtask

   task automatic done_with(input logic taken, input logic [31:0] tgt, input logic hlt);
      exec_done     = 1'b1;
      branch_taken  = taken;
      branch_target = tgt;
      halt          = hlt;
      step();
      exec_done     = 1'b0;
      branch_taken  = 1'b0;
      halt          = 1'b0;
   endtask

   task automatic retired(input string tag, input logic [31:0] exp);
`ifdef PC_RETIRE_COUNT_EN
      check(tag, retired_count, exp);
`else
      if (exp == 32'hFFFF_FFFF) $display("[TB] note %s", tag);
`endif
   endtask

   initial begin
      #12;
      check("rst_imem_req",    {31'd0, imem_req},    32'd0);
      check("rst_pc",          pc,                   RST_PC);
      check("rst_instr",       instr,                32'd0);
      check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_pc_sel",      {31'd0, pc_sel},      32'd0);
      check("rst_halted",      {31'd0, halted},      32'd0);
      check("rst_pc_plus4",    pc_plus4,             32'h104);
      retired("rst_retired", 32'd0);

      @(posedge clk); #1;
      rst_n = 1'b1;
      step();
      check("boot_req", {31'd0, imem_req}, 32'd1);
      check("boot_addr", imem_addr, 32'h100);
      req_cycles = imem_req ? 1 : 0;
      step();
      req_cycles += imem_req ? 1 : 0;
      fetch_with(32'hDEAD_BEEF);
      check("fetch1_req_cycles", req_cycles, 32'd2);
      check("fetch1_req_low", {31'd0, imem_req}, 32'd0);
      check("fetch1_instr", instr, 32'hDEAD_BEEF);
      check("fetch1_valid", {31'd0, instr_valid}, 32'd1);

      done_with(1'b0, 32'h0, 1'b0);
      check("seq_pc", pc, 32'h104);
      check("seq_pc_sel", {31'd0, pc_sel}, 32'd0);
      check("seq_req", {31'd0, imem_req}, 32'd1);
      check("seq_valid", {31'd0, instr_valid}, 32'd0);
      retired("seq_retired", 32'd1);

      done_with(1'b1, 32'h500, 1'b0);
      check("stray_done_pc", pc, 32'h104);
      check("stray_done_sel", {31'd0, pc_sel}, 32'd0);
      retired("stray_done_retired", 32'd1);

      fetch_with(32'h1111_1111);
      imem_ack  = 1'b1;
      imem_data = 32'h2222_2222;
      step();
      imem_ack  = 1'b0;
      check("stray_ack_instr", instr, 32'h1111_1111);
      check("stray_ack_valid", {31'd0, instr_valid}, 32'd1);

      done_with(1'b1, 32'h203, 1'b0);
      check("br_pc", pc, 32'h200);
      check("br_pc_sel", {31'd0, pc_sel}, 32'd1);
      check("br_req", {31'd0, imem_req}, 32'd1);
      check("br_pc_plus4", pc_plus4, 32'h204);

      fetch_with(32'h3333_3333);
      done_with(1'b1, 32'hFFFF_FFFE, 1'b0);
      check("br_top_pc", pc, 32'hFFFF_FFFC);
      check("br_top_plus4", pc_plus4, 32'h0);
      fetch_with(32'h4444_4444);
      done_with(1'b0, 32'h0, 1'b0);
      check("wrap_pc", pc, 32'h0);
      check("wrap_pc_sel", {31'd0, pc_sel}, 32'd0);

      fetch_with(32'h5555_5555);
      done_with(1'b1, 32'h301, 1'b0);
      check("br2_pc", pc, 32'h300);
      fetch_with(32'h6666_6666);
      done_with(1'b1, 32'h800, 1'b1);
      check("halt_halted", {31'd0, halted}, 32'd1);
      check("halt_pc", pc, 32'h300);
      check("halt_pc_sel", {31'd0, pc_sel}, 32'd1);
      check("halt_valid", {31'd0, instr_valid}, 32'd0);
      check("halt_req", {31'd0, imem_req}, 32'd0);
      retired("halt_retired", 32'd6);

      for (int i = 0; i < 3; i++) begin
         imem_ack  = 1'b1;
         imem_data = 32'h7777_7777;
         done_with(1'b1, 32'h900, 1'b0);
         imem_ack  = 1'b0;
         check($sformatf("halted_req_%0d", i), {31'd0, imem_req}, 32'd0);
         check($sformatf("halted_pc_%0d", i), pc, 32'h300);
      end
      check("halted_instr", instr, 32'h6666_6666);
      retired("halted_retired", 32'd6);

      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      step();
      step();
      fetch_with(32'h8888_8888);
      done_with(1'b0, 32'h0, 1'b0);
      retired("post_rst_retired", 32'd1);
      check("mid_fetch_pc_before", pc, 32'h104);
      imem_ack  = 1'b1;
      imem_data = 32'h9999_9999;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_req", {31'd0, imem_req}, 32'd0);
      check("async_rst_pc", pc, RST_PC);
      check("async_rst_instr", instr, 32'd0);
      check("async_rst_halted", {31'd0, halted}, 32'd0);
      retired("async_rst_retired", 32'd0);
      step();
      check("held_rst_req", {31'd0, imem_req}, 32'd0);
      imem_ack = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
